// File: rtl/sys_mem.sv
// Line-refill memory controller and backing store behind the I/D cache.
// Latency: beat k of a request accepted at edge T returns SysReady at T+(k+1)(WAIT+1).
// Backpressure: none toward the cache; new strobe edges are ignored while SysBusy is high.
//
// Ports:
//   clock, reset           system clock, synchronous active-high reset
//   SysStrobe, SysRW       request strobe (rising edge = request), 1 = line read, 0 = word write
//   SysAddress, SysData_in byte address (bits [1:0] ignored), write data
//   SysData_out            registered read data, held between beats
//   SysReady, SysBusy      one pulse per beat; busy from acceptance through the last beat
module sys_mem #(
  parameter int AW    = 10,
  parameter int WAIT  = 2,
  parameter int BURST = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        SysStrobe,
  input  logic        SysRW,
  input  logic [31:0] SysAddress,
  input  logic [31:0] SysData_in,
  output logic [31:0] SysData_out,
  output logic        SysReady,
  output logic        SysBusy
);

  localparam int BTW = (BURST > 1) ? $clog2(BURST) : 1;
  localparam int CW  = (WAIT > 1) ? $clog2(WAIT) : 1;
  localparam logic [AW-1:0]  LINE_MASK = AW'(BURST - 1);
  localparam logic [BTW-1:0] LAST_BEAT = BTW'(BURST - 1);
  localparam logic [CW-1:0]  LAST_WAIT = CW'(WAIT - 1);

  typedef enum logic [1:0] {IDLE, WAITS, BEAT} state_t;

  state_t         state;
  logic [31:0]    mem [2**AW];
  logic           rw;
  logic [31:0]    wdata;
  logic [AW-1:0]  base;
  logic [BTW-1:0] beat;
  logic [CW-1:0]  wc;
  logic           strb_q;
  logic           armed;
  logic [AW-1:0]  addr_w;
  logic [AW-1:0]  rd_addr;
  logic           accept;
  logic           unused_ok;

  assign addr_w    = SysAddress[AW+1:2];
  assign rd_addr   = base + AW'(beat);
  assign unused_ok = ^{SysAddress[31:AW+2], SysAddress[1:0]};

  // armed stays low after reset until the strobe has been seen low, so a
  // strobe held across reset is not mistaken for a fresh rising edge.
  // SysBusy still high in IDLE marks the drain cycle after the last beat.
  assign accept = (state == IDLE) && armed && SysStrobe && !strb_q && !SysBusy;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      SysReady    <= 1'b0;
      SysBusy     <= 1'b0;
      SysData_out <= '0;
      beat        <= '0;
      wc          <= '0;
      strb_q      <= 1'b0;
      armed       <= 1'b0;
      rw          <= 1'b0;
      wdata       <= '0;
      base        <= '0;
    end else begin
      strb_q   <= SysStrobe;
      SysReady <= 1'b0;
      if (!SysStrobe) armed <= 1'b1;
      case (state)
        IDLE: begin
          SysBusy <= 1'b0;
          if (accept) begin
            rw      <= SysRW;
            wdata   <= SysData_in;
            base    <= SysRW ? (addr_w & ~LINE_MASK) : addr_w;
            beat    <= '0;
            wc      <= '0;
            SysBusy <= 1'b1;
            state   <= (WAIT == 0) ? BEAT : WAITS;
          end
        end
        WAITS: begin
          wc <= wc + 1'b1;
          if (wc == LAST_WAIT) state <= BEAT;
        end
        BEAT: begin
          SysReady <= 1'b1;
          if (rw) SysData_out <= mem[rd_addr];
          if (!rw || beat == LAST_BEAT) begin
            state <= IDLE;
          end else begin
            beat  <= beat + 1'b1;
            wc    <= '0;
            state <= (WAIT == 0) ? BEAT : WAITS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Backing store is not reset; a write lands only in its BEAT cycle.
  always_ff @(posedge clock) begin
    if (!reset && state == BEAT && !rw) mem[base] <= wdata;
  end

endmodule

// File: doc/sys_mem.md
# sys_mem

System-side memory controller and backing store that sits directly downstream of the instruction/data cache. It serves the cache's `SysStrobe`/`SysRW`/`SysAddress` requests, returns a 16-word line refill as a paced burst of `SysReady` pulses, and performs single-word write-through stores. Its wait-state pacing models the main-memory latency the cache's refill counter is built around.

## Interface
- `AW`, default 10: word-address width of the backing array (2^AW 32-bit words).
- `WAIT`, default 2: wait cycles inserted before every data beat (0 allowed).
- `BURST`, default 16: words per line refill; must be a power of two.
- Clock and reset: one clock, `clock`; reset is `reset`, synchronous and active-high.
- `clock`  in  1  system clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `SysStrobe`  in  1  request strobe from the cache.
- `SysRW`  in  1  1 = read (line refill), 0 = write (single word).
- `SysAddress`  in  32  byte address; bits [1:0] ignored.
- `SysData_in`  in  32  write data from the cache.
- `SysData_out`  out  32  read data toward the cache, registered.
- `SysReady`  out  1  one-cycle pulse per completed beat.
- `SysBusy`  out  1  high from acceptance until the last beat's cycle, inclusive.

## Operation
- States are IDLE, WAITS and BEAT.
- Request acceptance:
  - A request is accepted in IDLE on the rising edge of `SysStrobe` (`SysStrobe`=1, previous-cycle `SysStrobe`=0).
  - The previous-cycle sample is also registered during busy states.
  - A strobe that is held high, or that rises while the block is busy, is not a new request.
- On acceptance the block latches the following:
  - `rw` = `SysRW`.
  - `wdata` = `SysData_in`.
  - Base word address:
    - Read: `SysAddress[AW+1:2]` with the low log2(BURST) bits forced to 0 (line-aligned).
    - Write: `SysAddress[AW+1:2]` unmodified.
  - Beat counter `beat`=0 and wait counter `wc`=0.
- Address bits above AW+1 are ignored, so addresses alias modulo 2^AW words.
- Transitions:
  - IDLE to WAITS on acceptance, or IDLE to BEAT if WAIT=0.
  - WAITS: `wc` increments every cycle. When `wc`==WAIT-1, go to BEAT.
  - BEAT asserts `SysReady` for one cycle and takes one of these actions:
    - Read: drives `SysData_out` = mem[base + beat].
    - Write: writes mem[base] = `wdata`. `SysData_out` is unchanged.
- Next state after BEAT:
  - Read with `beat` < BURST-1: `beat`++ and `wc`=0, then WAITS (or BEAT again if WAIT=0).
  - Read with `beat` = BURST-1, or any write: IDLE.
- Beats are delivered in ascending offset order, 0..BURST-1, matching the cache's refill counter, which starts at 0.
- The word offset is `beat` within the line, without wrapping into the neighbouring line.
- `SysData_out` holds its last value between beats and after a burst.
- The memory array is not reset; its contents are undefined until written or preloaded by the bench.

## Timing
- Reset values: state=IDLE, `SysReady`=0, `SysBusy`=0, `SysData_out`=0, `beat`=0, `wc`=0, strobe history=0.
- Reset during a request:
  - The request is aborted on the next edge and no further `SysReady` is produced.
  - A write whose BEAT cycle has not occurred does not modify memory.
  - A strobe still high after reset deasserts is not accepted until it drops and rises again.
- With the acceptance edge at cycle T, `SysReady` for beat k is high in cycle T+(k+1)(WAIT+1), counting cycles after the accept edge.
- Read latency:
  - First word at T+WAIT+1.
  - Last word at T+BURST(WAIT+1).
  - With the defaults, words land at T+3, T+6, …, T+48.
- Write latency: single `SysReady` at T+WAIT+1; the memory update is visible to any later read.
- `SysBusy` falls in the cycle after the final `SysReady`.
- The earliest next acceptance is the cycle after `SysBusy` falls, and only with a fresh strobe rising edge.
- `SysData_out` is valid in the same cycle `SysReady` is high and stays stable otherwise.

## Test plan
- Reset, then idle 5 cycles:
  - `SysReady`=0, `SysBusy`=0, `SysData_out`=0 throughout.
- Write 0xDEADBEEF to 0x00000044, strobe pulsed 1 cycle at T:
  - `SysReady` only at T+3, `SysBusy` high T..T+3.
  - A later read of line 0x40 returns 0xDEADBEEF on beat 1.
- Preload mem[w]=w*0x11 for w in 0..31, then read `SysAddress`=0x00000068:
  - Base is line 0x40 (words 16..31).
  - 16 `SysReady` pulses at T+3, T+6, …, T+48 with data 0x110, 0x121, …, 0x20F in order.
- Hold `SysStrobe` high for 60 cycles:
  - Exactly one burst of 16 beats and no second request.
  - Drop the strobe, raise it again: a new burst starts.
- Assert `reset` in cycle T+7 of a read burst:
  - No `SysReady` after T+6 and the outputs return to reset values.
  - Also assert reset at T+1 of a write: the target word is unchanged.
- Rebuild with WAIT=0, BURST=4, AW=4 and read address 0x000000F0:
  - Aliases to words 12..15.
  - `SysReady` at T+1..T+4 consecutively.
